// File: rtl/block_check_scheduler.sv
// block_check_scheduler: round-robin sharing of one BlockChecker between N_REQ character-stream requesters.
// Ports: clk, reset (sync, active-high); req_valid/req_char/req_ready per requester (char i on req_char[8i+:8]);
// done (one-hot pulse per finished message), verdict/timeout (valid with done, held);
// chk_reset/chk_in drive the checker, chk_result comes back from it.
// Optional watchdog: define BLOCK_SCHED_WDOG_EN to abort messages longer than MAX_LEN chars.
module block_check_scheduler #(
  parameter int N_REQ = 2,
  parameter logic [7:0] TERM_CHAR = 8'h2E,
  parameter logic [7:0] SEP_CHAR = 8'h20,
  parameter int MAX_LEN = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_char,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   done,
  output logic               verdict,
  output logic               timeout,
  output logic               chk_reset,
  output logic [7:0]         chk_in,
  input  logic               chk_result
);
  localparam int GW = $clog2(N_REQ);
  typedef enum logic [2:0] {
    IDLE, CLEAR, STREAM, WAIT, DONE
`ifdef BLOCK_SCHED_WDOG_EN
    , DRAIN
`endif
  } state_t;
  state_t state;
  logic [GW-1:0] g, rr, win;
  logic any, gv, is_term, fwd, full, draining;
  logic [7:0] gch;
  logic [N_REQ-1:0] g_hot;
`ifdef BLOCK_SCHED_WDOG_EN
  localparam int CW = $clog2(MAX_LEN+1);
  logic [CW-1:0] cnt;
  assign full = cnt == CW'(MAX_LEN);
  assign draining = state == DRAIN;
`else
  assign full = 1'b0;
  assign draining = 1'b0;
`endif
  // descending scan so the candidate nearest the rr pointer is assigned last and wins
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = N_REQ-1; k >= 0; k--)
      if (req_valid[GW'((int'(rr)+k) % N_REQ)]) begin
        win = GW'((int'(rr)+k) % N_REQ);
        any = 1'b1;
      end
  end
  assign gch = req_char[8*g +: 8];
  assign gv = req_valid[g];
  assign is_term = gch == TERM_CHAR;
  assign g_hot = N_REQ'(1) << g;
  // a stalled requester or the terminator sends a separator so the checker closes the current word
  assign fwd = state == STREAM && gv && !is_term && !full;
  assign chk_in = fwd ? gch : SEP_CHAR;
  assign req_ready = (state == STREAM || draining) ? g_hot : '0;
  assign chk_reset = reset | (state == CLEAR);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr <= '0;
      g <= '0;
      done <= '0;
      verdict <= 1'b0;
      timeout <= 1'b0;
`ifdef BLOCK_SCHED_WDOG_EN
      cnt <= '0;
`endif
    end else begin
      done <= '0;
      case (state)
        IDLE: if (any) begin
          g <= win;
          state <= CLEAR;
        end
        CLEAR: begin
          state <= STREAM;
`ifdef BLOCK_SCHED_WDOG_EN
          cnt <= '0;
`endif
        end
        STREAM: begin
`ifdef BLOCK_SCHED_WDOG_EN
          if (fwd) cnt <= cnt + CW'(1);
          // a terminator arriving at the limit still completes normally
          if (gv && full && !is_term) state <= DRAIN;
`endif
          if (gv && is_term) state <= WAIT;
        end
        WAIT: begin
          verdict <= chk_result;
          timeout <= 1'b0;
          done <= g_hot;
          state <= DONE;
        end
        DONE: begin
          rr <= (g == GW'(N_REQ-1)) ? '0 : g + GW'(1);
          state <= IDLE;
        end
`ifdef BLOCK_SCHED_WDOG_EN
        DRAIN: if (gv && is_term) begin
          verdict <= 1'b0;
          timeout <= 1'b1;
          done <= g_hot;
          state <= DONE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_block_check_scheduler.sv
// tb_block_check_scheduler: directed and random messages against a string-level model of the scheduler.
module tb_block_check_scheduler;
  localparam int N = 2;
  localparam logic [7:0] SEP = 8'h20;
  localparam logic [7:0] TERM = 8'h2E;
`ifdef BLOCK_SCHED_WDOG_EN
  localparam int ML = 4;
  localparam bit WD = 1'b1;
`else
  localparam int ML = 64;
  localparam bit WD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic v [N];
  logic [7:0] ch [N];
  logic [N-1:0] req_valid, req_ready, done;
  logic [8*N-1:0] req_char;
  logic verdict, timeout, chk_reset, chk_result;
  logic [7:0] chk_in;
  int n_vec = 0;
  int n_err = 0;
  int rr_m = 0;
  int order [$];
  assign req_valid = {v[1], v[0]};
  assign req_char = {ch[1], ch[0]};
  always #5 clk = ~clk;
  block_check_scheduler #(.N_REQ(N), .MAX_LEN(ML)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_char(req_char),
    .req_ready(req_ready), .done(done), .verdict(verdict), .timeout(timeout),
    .chk_reset(chk_reset), .chk_in(chk_in), .chk_result(chk_result)
  );
  // stand-in BlockChecker: case-insensitive begin/end nesting, any other word is an error
  logic [63:0] w;
  int wlen, depth, d_n;
  bit err, e_n;
  logic [7:0] lc;
  always_comb begin
    lc = (chk_in >= "A" && chk_in <= "Z") ? chk_in + 8'h20 : chk_in;
    d_n = depth;
    e_n = err;
    if (wlen == 5 && w[39:0] == "begin") d_n = depth + 1;
    else if (wlen == 3 && w[23:0] == "end") begin
      if (depth == 0) e_n = 1'b1;
      else d_n = depth - 1;
    end else if (wlen != 0) e_n = 1'b1;
  end
  always @(posedge clk)
    if (chk_reset) begin
      depth <= 0; err <= 1'b0; w <= '0; wlen <= 0; chk_result <= 1'b0;
    end else if (chk_in == SEP) begin
      depth <= d_n; err <= e_n; w <= '0; wlen <= 0; chk_result <= !e_n && d_n == 0;
    end else begin
      w <= {w[55:0], lc}; wlen <= wlen + 1;
    end
  function automatic bit model_v(input string s);
    int d = 0;
    bit e = 1'b0;
    string wd = "";
    string t = {s, " "};
    for (int i = 0; i < t.len(); i++)
      if (t.substr(i, i) == " ") begin
        if (wd.len() > 0) begin
          wd = wd.tolower();
          if (wd == "begin") d++;
          else if (wd == "end" && d > 0) d--;
          else e = 1'b1;
          wd = "";
        end
      end else wd = {wd, t.substr(i, i)};
    return !e && d == 0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1; v[0] = 1'b0; v[1] = 1'b0; ch[0] = 8'h0; ch[1] = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_verdict", verdict, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_chk_in", chk_in, SEP);
    chk("rst_chk_reset", chk_reset, 1);
    reset = 1'b0;
    rr_m = 0;
    @(posedge clk);
    #1;
  endtask
  // stream message m from requester r, stalling gl cycles before char gp; check forwarding and completion
  task automatic send(input int r, input string m, input int gp, input int gl);
    int idx = 0, wc = 0, gap = gl, nf = 0;
    string fw = "";
    bit act, te;
    logic [7:0] c, e;
    v[r] = 1'b1; ch[r] = m[0];
    while (req_ready[r] !== 1'b1) begin
      @(posedge clk);
      #1;
      if (++wc > 200) begin
        n_err++;
        $error("FAIL grant_wait r%0d: observed no grant expected grant", r);
        $fatal(1, "grant wait expired");
      end
    end
    while (idx < m.len()) begin
      c = m[idx];
      act = !(idx == gp && gap > 0);
      v[r] = act; ch[r] = c;
      @(negedge clk);
      chk("ready_grant", req_ready, 1 << r);
      e = (!act || c == TERM || (WD && nf >= ML)) ? SEP : c;
      chk("chk_in", chk_in, e);
      @(posedge clk);
      #1;
      if (!act) begin
        gap--;
        fw = {fw, " "};
      end else begin
        if (c != TERM) begin
          if (!(WD && nf >= ML)) fw = {fw, m.substr(idx, idx)};
          nf++;
        end
        idx++;
      end
    end
    v[r] = 1'b0;
    te = WD && nf > ML;
    if (!te) begin
      chk("done_early", done, 0);
      @(posedge clk);
      #1;
    end
    chk("done", done, 1 << r);
    chk("verdict", verdict, te ? 0 : model_v(fw));
    chk("timeout", timeout, te);
    order.push_back(r);
    rr_m = (r + 1) % N;
  endtask
  task automatic pair(input string m0, input string m1);
    int first = rr_m;
    fork
      send(0, m0, 99, 0);
      send(1, m1, 99, 0);
    join
    chk("rr_order", order[order.size()-2], first);
  endtask
  initial begin
    string words [6] = '{"begin", "end", "BEGIN", "End", "foo", "beginend"};
    string m;
    int n, r;
    do_reset();
    send(0, "begin end.", 99, 0);
    send(0, "begin .", 99, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("verdict_hold", verdict, 0);
    chk("done_idle", done, 0);
    do_reset();
    pair("begin end.", "end.");
    pair("begin end.", "end.");
    send(1, "BEGINEnd.", 5, 3);
    v[0] = 1'b1; ch[0] = "b";
    repeat (3) @(posedge clk);
    #1;
    chk("mid_ready", req_ready, 1);
    reset = 1'b1; v[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_ready_rst", req_ready, 0);
    chk("mid_done_rst", done, 0);
    chk("mid_chk_reset", chk_reset, 1);
    chk("mid_verdict", verdict, 0);
    reset = 1'b0; rr_m = 0;
    @(posedge clk);
    #1;
    send(0, "begin end.", 99, 0);
    send(0, "beginend.", 99, 0);
    send(1, "abcd.", 99, 0);
    for (int i = 0; i < 30; i++) begin
      m = "";
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) begin
        m = {m, words[$urandom_range(0, 5)]};
        if (k < n - 1) m = {m, " "};
      end
      m = {m, "."};
      r = $urandom_range(0, N - 1);
      send(r, m, $urandom_range(0, m.len() - 1), $urandom_range(0, 3));
    end
    pair("end.", "BEGIN begin end END.");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #500000;
    $error("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end
endmodule
